// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: sequences operand reads and queued writebacks onto a single-port 32x32 register file.
// Optional feature macro REGFILE_ACCESS_FWD_EN: reads forward from pending writebacks instead of stalling on them.
module regfile_access_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        t2,
  input  logic        rst_n,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic [4:0]  rd_ra,
  input  logic [4:0]  rd_rb,
  output logic        op_valid,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic [4:0]  rf_ar,
  output logic [4:0]  rf_br,
  input  logic [31:0] rf_a,
  input  logic [31:0] rf_b,
  output logic        rf_rwe,
  output logic [4:0]  rf_wr,
  output logic [31:0] rf_w,
  output logic        idle
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE, S_RDATA} state_t;
  state_t state, state_next;

  logic [4:0]    q_reg  [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic        hit_a, hit_b, hazard, accept, drain, push;
  logic [31:0] fwd_a, fwd_b;
  logic        hit_a_q, hit_b_q, zero_a_q, zero_b_q;
  logic [31:0] fwd_a_q, fwd_b_q;

  // Scan oldest to youngest so the youngest matching entry wins for each source.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    fwd_a = '0;
    fwd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if (rd_ra != 5'd0 && q_reg[rd_ptr + AW'(i)] == rd_ra) begin
          hit_a = 1'b1;
          fwd_a = q_data[rd_ptr + AW'(i)];
        end
        if (rd_rb != 5'd0 && q_reg[rd_ptr + AW'(i)] == rd_rb) begin
          hit_b = 1'b1;
          fwd_b = q_data[rd_ptr + AW'(i)];
        end
      end
    end
  end

`ifdef REGFILE_ACCESS_FWD_EN
  assign hazard = 1'b0;
`else
  assign hazard = hit_a | hit_b;
`endif

  assign wb_ready = (count != CW'(DEPTH));
  assign idle     = (state == S_IDLE) && (count == '0);
  assign rf_ar    = rd_ra;
  assign rf_br    = rd_rb;
  assign rf_rwe   = drain;
  assign rf_wr    = q_reg[rd_ptr];
  assign rf_w     = q_data[rd_ptr];

  always_comb begin
    state_next = state;
    rd_ready   = (state == S_IDLE) && !hazard;
    accept     = rd_valid && rd_ready;
    drain      = !accept && (count != '0);
    push       = wb_valid && wb_ready && (wb_reg != 5'd0);
    case (state)
      S_IDLE:  if (accept) state_next = S_RDATA;
      S_RDATA: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge t2 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge t2 or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (drain) rd_ptr <= rd_ptr + 1'b1;
      if (push && !drain)      count <= count + 1'b1;
      else if (!push && drain) count <= count - 1'b1;
    end
  end

  always_ff @(posedge t2) begin
    if (push) begin
      q_reg[wr_ptr]  <= wb_reg;
      q_data[wr_ptr] <= wb_data;
    end
  end

  // Forwarding decisions are frozen at accept; the register file data arrives one cycle later.
  always_ff @(posedge t2 or negedge rst_n) begin
    if (!rst_n) begin
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      hit_a_q  <= 1'b0;
      hit_b_q  <= 1'b0;
      zero_a_q <= 1'b0;
      zero_b_q <= 1'b0;
      fwd_a_q  <= '0;
      fwd_b_q  <= '0;
    end else begin
      op_valid <= (state == S_RDATA);
      if (accept) begin
        zero_a_q <= (rd_ra == 5'd0);
        zero_b_q <= (rd_rb == 5'd0);
        hit_a_q  <= hit_a;
        hit_b_q  <= hit_b;
        fwd_a_q  <= fwd_a;
        fwd_b_q  <= fwd_b;
      end
      if (state == S_RDATA) begin
        op_a <= zero_a_q ? '0 : (hit_a_q ? fwd_a_q : rf_a);
        op_b <= zero_b_q ? '0 : (hit_b_q ? fwd_b_q : rf_b);
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: drives directed and random traffic and compares against an architectural
// register-file model plus an in-order list of pending writes.
module tb_regfile_access_ctrl;
  localparam int DEPTH = 4;

  logic        t2, rst_n;
  logic        rd_valid, rd_ready, op_valid, wb_valid, wb_ready, rf_rwe, idle;
  logic [4:0]  rd_ra, rd_rb, wb_reg, rf_ar, rf_br, rf_wr;
  logic [31:0] op_a, op_b, wb_data, rf_a, rf_b, rf_w;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic [4:0] r; logic [31:0] d; } wr_t;
  typedef struct { logic [31:0] a; logic [31:0] b; int due; } rd_t;
  wr_t exp_wq[$];
  rd_t exp_rq[$];
  logic [31:0] rfmem [32];
  logic [31:0] arch  [32];
  bit   busy = 1'b0;
  logic seeded = 1'b0;

  regfile_access_ctrl #(.DEPTH(DEPTH)) dut (
    .t2(t2), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ra(rd_ra), .rd_rb(rd_rb),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
    .rf_ar(rf_ar), .rf_br(rf_br), .rf_a(rf_a), .rf_b(rf_b),
    .rf_rwe(rf_rwe), .rf_wr(rf_wr), .rf_w(rf_w), .idle(idle)
  );

  initial begin
    t2 = 1'b0;
    forever #5 t2 = ~t2;
  end

  // Register file: read data registered, contents survive controller reset.
  always @(posedge t2) begin
    if (!seeded) begin
      for (int i = 0; i < 32; i++) rfmem[i] <= $urandom | 32'h1;
      seeded <= 1'b1;
      rf_a   <= '0;
      rf_b   <= '0;
    end else begin
      if (rf_rwe === 1'b1) rfmem[rf_wr] <= rf_w;
      rf_a <= rfmem[rf_ar];
      rf_b <= rfmem[rf_br];
    end
  end

  // Reference model: a read returns the architectural value at accept; writes retire in order.
  always @(negedge t2) begin
    bit acc, wacc, haz, exp_rdy, exp_rwe;
    wr_t w;
    rd_t r;
    if (!rst_n) begin
      exp_wq.delete();
      exp_rq.delete();
      busy = 1'b0;
      for (int i = 0; i < 32; i++) arch[i] = rfmem[i];
    end else begin
      cyc++;
      acc  = (rd_valid === 1'b1) && (rd_ready === 1'b1);
      wacc = (wb_valid === 1'b1) && (wb_ready === 1'b1);
      checks++;
      if (exp_rq.size() > 0 && exp_rq[0].due == cyc) begin
        r = exp_rq.pop_front();
        if (op_valid !== 1'b1 || op_a !== r.a || op_b !== r.b) begin
          errors++;
          $display("[TB] FAIL operand: got valid=%b a=%h b=%h expected valid=1 a=%h b=%h",
                   op_valid, op_a, op_b, r.a, r.b);
        end
      end else if (op_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL op_valid_spurious: got %b expected 0 (cycle %0d)", op_valid, cyc);
      end
      haz = 1'b0;
      foreach (exp_wq[i])
        if ((rd_ra != 5'd0 && exp_wq[i].r == rd_ra) || (rd_rb != 5'd0 && exp_wq[i].r == rd_rb)) haz = 1'b1;
`ifdef REGFILE_ACCESS_FWD_EN
      haz = 1'b0;
`endif
      exp_rdy = !busy && !haz;
      checks++;
      if (rd_ready !== exp_rdy) begin
        errors++;
        $display("[TB] FAIL rd_ready: got %b expected %b (cycle %0d)", rd_ready, exp_rdy, cyc);
      end
      checks++;
      if (wb_ready !== (exp_wq.size() < DEPTH)) begin
        errors++;
        $display("[TB] FAIL wb_ready: got %b expected %b (cycle %0d)", wb_ready, exp_wq.size() < DEPTH, cyc);
      end
      checks++;
      if (idle !== (!busy && exp_wq.size() == 0)) begin
        errors++;
        $display("[TB] FAIL idle: got %b expected %b (cycle %0d)", idle, !busy && exp_wq.size() == 0, cyc);
      end
      exp_rwe = !acc && exp_wq.size() > 0;
      checks++;
      if (rf_rwe !== exp_rwe) begin
        errors++;
        $display("[TB] FAIL rf_rwe: got %b expected %b (cycle %0d)", rf_rwe, exp_rwe, cyc);
      end
      if (rf_rwe === 1'b1 && exp_wq.size() > 0) begin
        w = exp_wq.pop_front();
        checks++;
        if (rf_wr !== w.r || rf_w !== w.d) begin
          errors++;
          $display("[TB] FAIL drain_order: got r%0d=%h expected r%0d=%h", rf_wr, rf_w, w.r, w.d);
        end
      end
      if (acc) begin
        r.a   = (rd_ra == 5'd0) ? 32'h0 : arch[rd_ra];
        r.b   = (rd_rb == 5'd0) ? 32'h0 : arch[rd_rb];
        r.due = cyc + 2;
        exp_rq.push_back(r);
      end
      if (wacc && wb_reg != 5'd0) begin
        arch[wb_reg] = wb_data;
        w.r = wb_reg;
        w.d = wb_data;
        exp_wq.push_back(w);
      end
      busy = acc;
    end
  end

  task automatic step();
    @(posedge t2);
    #1;
  endtask

  task automatic push_write(input logic [4:0] r, input logic [31:0] d, output int stalls);
    bit ok;
    ok = 1'b0;
    stalls = 0;
    wb_valid = 1'b1;
    wb_reg = r;
    wb_data = d;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge t2);
      ok = (wb_ready === 1'b1);
      if (!ok) stalls++;
      step();
    end
    wb_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL push_timeout: got no accept expected accept for r%0d", r);
    end
  endtask

  task automatic do_read(input logic [4:0] ra, input logic [4:0] rb, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    rd_valid = 1'b1;
    rd_ra = ra;
    rd_rb = rb;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge t2);
      ok = (rd_ready === 1'b1);
      if (!ok) waited++;
      step();
    end
    rd_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL read_timeout: got no accept expected accept for ra=%0d rb=%0d", ra, rb);
    end
  endtask

  task automatic wait_op(output logic [31:0] a, output logic [31:0] b, output int lat);
    bit ok;
    ok = 1'b0;
    a = '0;
    b = '0;
    lat = 0;
    for (int n = 1; n <= 20 && !ok; n++) begin
      @(negedge t2);
      if (op_valid === 1'b1) begin
        ok = 1'b1;
        a = op_a;
        b = op_b;
        lat = n;
      end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL op_timeout: got no op_valid expected op_valid within 20 cycles");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge t2);
      ok = (idle === 1'b1);
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL idle_timeout: got idle=%b expected 1", idle);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge t2);
    checks += 6;
    if (op_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_op_valid: got %b expected 0", op_valid); end
    if (op_a !== 32'h0)    begin errors++; $display("[TB] FAIL rst_op_a: got %h expected 0", op_a); end
    if (op_b !== 32'h0)    begin errors++; $display("[TB] FAIL rst_op_b: got %h expected 0", op_b); end
    if (rf_rwe !== 1'b0)   begin errors++; $display("[TB] FAIL rst_rf_rwe: got %b expected 0", rf_rwe); end
    if (idle !== 1'b1)     begin errors++; $display("[TB] FAIL rst_idle: got %b expected 1", idle); end
    if (wb_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_wb_ready: got %b expected 1", wb_ready); end
    step();
    rst_n = 1'b1;
    @(negedge t2);
    checks++;
    if (rd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rel_rd_ready: got %b expected 1", rd_ready); end
    step();
  endtask

  task automatic test_basic_read();
    int s, w, lat;
    logic [31:0] a, b;
    push_write(5'd5, 32'hDEADBEEF, s);
    wait_idle();
    do_read(5'd5, 5'd0, w);
    wait_op(a, b, lat);
    checks += 3;
    if (lat != 2)          begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 2", lat); end
    if (a !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL basic_op_a: got %h expected deadbeef", a); end
    if (b !== 32'h0)       begin errors++; $display("[TB] FAIL basic_op_b: got %h expected 0", b); end
  endtask

  task automatic test_reg0();
    int s, w, lat;
    logic [31:0] a, b;
    wait_idle();
    push_write(5'd0, 32'h1234, s);
    for (int n = 0; n < 4; n++) begin
      @(negedge t2);
      checks++;
      if (rf_rwe !== 1'b0) begin errors++; $display("[TB] FAIL r0_write: got rf_rwe=%b expected 0", rf_rwe); end
      step();
    end
    do_read(5'd0, 5'd0, w);
    wait_op(a, b, lat);
    checks += 2;
    if (a !== 32'h0) begin errors++; $display("[TB] FAIL r0_op_a: got %h expected 0", a); end
    if (b !== 32'h0) begin errors++; $display("[TB] FAIL r0_op_b: got %h expected 0", b); end
  endtask

  task automatic test_forwarding();
    int s, w, lat;
    logic [31:0] a, b;
    wait_idle();
    push_write(5'd3, 32'd1, s);
    push_write(5'd3, 32'd2, s);
    do_read(5'd3, 5'd0, w);
    checks++;
`ifdef REGFILE_ACCESS_FWD_EN
    if (w != 0) begin errors++; $display("[TB] FAIL fwd_stall: got %0d stall cycles expected 0", w); end
`else
    if (w < 1) begin errors++; $display("[TB] FAIL hazard_stall: got %0d stall cycles expected at least 1", w); end
`endif
    wait_op(a, b, lat);
    checks++;
    if (a !== 32'd2) begin errors++; $display("[TB] FAIL fwd_op_a: got %h expected 2", a); end
  endtask

  task automatic test_queue_full();
    int s, total;
    total = 0;
    wait_idle();
    rd_valid = 1'b1;
    rd_ra = 5'd0;
    rd_rb = 5'd0;
    for (int i = 1; i <= 10; i++) begin
      push_write(5'(i), 32'h1000_0000 + 32'(i), s);
      total += s;
    end
    rd_valid = 1'b0;
    checks++;
    if (total == 0) begin errors++; $display("[TB] FAIL full_stall: got %0d stall cycles expected >0", total); end
    wait_idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rd_valid = 1'($urandom_range(0, 1));
      rd_ra    = 5'($urandom_range(0, 7));
      rd_rb    = 5'($urandom_range(0, 7));
      wb_valid = ($urandom_range(0, 4) < 2);
      wb_reg   = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      step();
    end
    rd_valid = 1'b0;
    wb_valid = 1'b0;
    wait_idle();
    repeat (3) step();
    checks++;
    if (exp_wq.size() != 0) begin errors++; $display("[TB] FAIL rand_drain: got %0d pending expected 0", exp_wq.size()); end
  endtask

  task automatic test_reset_mid();
    int s;
    wait_idle();
    push_write(5'd9, 32'hCAFE0009, s);
    rd_valid = 1'b1;
    rd_ra = 5'd0;
    rd_rb = 5'd0;
    wb_valid = 1'b1;
    wb_reg = 5'd10;
    wb_data = 32'hCAFE000A;
    @(negedge t2);
    checks++;
    if (rd_ready !== 1'b1 || wb_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_setup: got rd_ready=%b wb_ready=%b expected 1 1", rd_ready, wb_ready);
    end
    step();
    rd_valid = 1'b0;
    wb_valid = 1'b0;
    checks++;
    if (rd_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rdata: got rd_ready=%b expected 0", rd_ready); end
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge t2);
      checks += 3;
      if (op_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_op_valid: got %b expected 0", op_valid); end
      if (rf_rwe !== 1'b0)   begin errors++; $display("[TB] FAIL mid_rf_rwe: got %b expected 0", rf_rwe); end
      if (idle !== 1'b1)     begin errors++; $display("[TB] FAIL mid_idle: got %b expected 1", idle); end
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rd_valid = 1'b0;
    rd_ra = '0;
    rd_rb = '0;
    wb_valid = 1'b0;
    wb_reg = '0;
    wb_data = '0;
    test_reset();
    test_basic_read();
    test_reg0();
    test_forwarding();
    test_queue_full();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Initiator-side controller for the CPU's 32×32 register file. It sequences operand reads and buffered writebacks onto the register file's single time-multiplexed port: a write cycle when `rf_rwe`=1, a read-latch cycle otherwise. Writebacks are held in a small in-order queue and drained in cycles where no read is being issued. An optional forwarding path lets reads bypass pending writes. It sits between the decode/writeback stages and the register file.

## Interface
- `DEPTH`, 4: writeback queue entries; power of two, ≥2.

- `t2` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rd_valid` in 1: operand-read request.
- `rd_ready` out 1: read request accepted when `rd_valid && rd_ready`.
- `rd_ra` in 5: source register A index.
- `rd_rb` in 5: source register B index.
- `op_valid` out 1: one-cycle pulse; `op_a`/`op_b` valid.
- `op_a` out 32: register A value.
- `op_b` out 32: register B value.
- `wb_valid` in 1: writeback request.
- `wb_ready` out 1: writeback accepted when `wb_valid && wb_ready`.
- `wb_reg` in 5: destination register index.
- `wb_data` in 32: writeback data.
- `rf_ar` out 5: register file read index A.
- `rf_br` out 5: register file read index B.
- `rf_a` in 32: register file read data A, registered by the register file.
- `rf_b` in 32: register file read data B, registered by the register file.
- `rf_rwe` out 1: register file write enable.
- `rf_wr` out 5: register file write index.
- `rf_w` out 32: register file write data.
- `idle` out 1: FSM in `S_IDLE` and queue empty.

## Operation
- **FSM states**
  - `S_IDLE`: `rd_ready`=1, subject to the hazard rule below.
  - On read accept: `rf_ar`=`rd_ra` and `rf_br`=`rd_rb` (combinational), `rf_rwe`=0 in the same cycle. Latch indices. Go to `S_RDATA`.
  - `S_RDATA`: `rd_ready`=0. Sample `rf_a`/`rf_b`, merged with the forwarding/zero rules, into `op_a`/`op_b`. Assert `op_valid` next cycle. Return to `S_IDLE`.
- **Write queue**
  - FIFO of {reg, data}, `DEPTH` entries. `wb_ready` = !full.
  - Writes to r0 are accepted and discarded, never enqueued.
- **Drain**
  - A drain cycle is any cycle without a read accept: `S_IDLE` with no accept, or `S_RDATA`.
  - In a drain cycle with the queue non-empty: `rf_rwe`=1, `rf_wr`/`rf_w` = head, pop.
  - Exactly one pop per drain cycle.
  - Otherwise `rf_rwe`=0; `rf_wr`/`rf_w` are don't-care, but the block drives the head.
- **Priority**
  - Read accept beats drain.
  - Push and pop in the same cycle are allowed; count is unchanged.
- **Register 0**
  - Reading index 0 always returns 0, regardless of `rf_a`/`rf_b`.
- **Ordering**
  - Forwarding and the hazard check see queue contents at the start of the accept cycle.
  - A writeback enqueued in the same cycle as a read accept is ordered after that read; the read sees the old value.

## Timing
- **Read latency:** accept in cycle N → register file latches at the end of N → `op_valid`=1 in cycle N+2 for exactly one cycle. `op_a`/`op_b` hold until the next `op_valid`.
- **Read throughput:** max one read per 2 cycles.
- **Write drain:** up to one write per cycle when no reads are issued.
- **Reset values (`rst_n`=0, asynchronous):**
  - State `S_IDLE`, queue empty.
  - `op_valid`=0, `op_a`=`op_b`=0.
  - `rf_rwe`=0, `idle`=1.
  - `wb_ready`=1, `rd_ready`=1 after reset release.
- **Reset mid-operation:** a pending read is dropped (no `op_valid`); queued writes are lost.

## Configuration
- **`REGFILE_ACCESS_FWD_EN` defined:**
  - At accept, for each nonzero source index, the youngest matching queue entry's data replaces the register file value.
  - Reads never stall on hazards.
- **`REGFILE_ACCESS_FWD_EN` undefined:**
  - A hazard exists when `rd_ra` or `rd_rb` (nonzero) matches any queued entry.
  - During a hazard `rd_ready`=0 (combinational on `rd_ra`/`rd_rb`) and the queue drains.
  - The read is accepted once no match remains.

## Test plan
- **Reset:** hold `rst_n`=0, then release → `op_valid`=0, `op_a`=`op_b`=0, `rf_rwe`=0, `rd_ready`=`wb_ready`=`idle`=1.
- **Basic read:** write r5=0xDEADBEEF, wait for `idle`, read ra=5 rb=0 at cycle N → `op_valid` at N+2, `op_a`=0xDEADBEEF, `op_b`=0.
- **Queue full:**
  - Stimulus: hold `rd_valid`=1 with ra=rb=0, and push 4 writes r1..r4 in consecutive cycles.
  - Required: `wb_ready`=0 when full; fifth write stalls until a drain cycle.
  - Required: drains occur only in `S_RDATA` cycles.
- **Forwarding:** enqueue r3=1 then r3=2, then immediately read ra=3.
  - With `REGFILE_ACCESS_FWD_EN`: accepted at once, `op_a`=2.
  - Without: `rd_ready`=0 until both entries are drained, then `op_a`=2.
- **Register 0:** write r0=0x1234 → no `rf_rwe` pulse; read ra=0 → `op_a`=0.
- **Reset mid-read:** pull `rst_n` low in `S_RDATA` with 2 entries queued → no `op_valid`, `idle`=1, no further `rf_rwe`.
